iter_alu: RTL and testbench

Parametrised, registered ALU with a valid/ready handshake on both sides. It executes the bitwise, pass, LUI and compare operations in one cycle. Shifts run iteratively, one bit position per cycle, and multiply runs as a WIDTH-cycle shift-add. It sits between the decode/operand-fetch stage and writeback, and it stalls the front end through `in_ready` while a multi-cycle operation is in flight.

---
 rtl/iter_alu.sv | 204 ++++++++++++++++++++
 tb/tb_iter_alu.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/iter_alu.sv
`default_nettype none
// ============================================================================
//  Module      : iter_alu
//  Description : Registered ALU with valid/ready handshakes. Logic, pass, LUI,
//                add/sub and compares complete in one cycle; shifts step one
//                bit per cycle and multiply is a WIDTH-cycle shift-add.
//  Revision    : 1.0 - initial release
// ============================================================================
module iter_alu #(
    parameter int WIDTH = 32,
    parameter int SW    = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             ovf
);

    localparam logic [3:0] c_OP_OR    = 4'd0;
    localparam logic [3:0] c_OP_AND   = 4'd1;
    localparam logic [3:0] c_OP_XOR   = 4'd2;
    localparam logic [3:0] c_OP_NOR   = 4'd3;
    localparam logic [3:0] c_OP_NOTA  = 4'd4;
    localparam logic [3:0] c_OP_PASSA = 4'd5;
    localparam logic [3:0] c_OP_PASSB = 4'd6;
    localparam logic [3:0] c_OP_LUI   = 4'd7;
    localparam logic [3:0] c_OP_ADD   = 4'd8;
    localparam logic [3:0] c_OP_SUB   = 4'd9;
    localparam logic [3:0] c_OP_SLT   = 4'd10;
    localparam logic [3:0] c_OP_SGT   = 4'd11;
    localparam logic [3:0] c_OP_SLL   = 4'd12;
    localparam logic [3:0] c_OP_SRL   = 4'd13;
    localparam logic [3:0] c_OP_SRA   = 4'd14;
    localparam logic [3:0] c_OP_MUL   = 4'd15;

    localparam int         c_MSB       = WIDTH - 1;
    localparam int         c_HALF      = WIDTH / 2;
    // Counter is one bit wider than SW so it can hold WIDTH for multiply
    localparam logic [SW:0] c_MUL_STEPS = (SW+1)'(WIDTH);
    localparam logic [SW:0] c_CNT_ONE   = (SW+1)'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_MUL   = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t             r_state;
    logic [3:0]         r_op;
    logic [SW:0]        r_cnt;
    logic [WIDTH-1:0]   r_acc;
    logic [WIDTH-1:0]   r_mcand;
    logic [WIDTH-1:0]   r_mplier;
    logic [WIDTH-1:0]   r_result;
    logic               r_zero;
    logic               r_ovf;

    logic [WIDTH-1:0]   w_sum;
    logic [WIDTH-1:0]   w_diff;
    logic               w_add_ovf;
    logic               w_sub_ovf;
    logic               w_lt;
    logic               w_eq;
    logic [WIDTH-1:0]   w_alu_res;
    logic               w_alu_ovf;
    logic [SW-1:0]      w_shamt;
    logic               w_is_shift;
    logic [WIDTH-1:0]   w_shift_next;
    logic [WIDTH-1:0]   w_mul_next;

    assign w_sum      = a + b;
    assign w_diff     = a - b;
    assign w_add_ovf  = (a[c_MSB] == b[c_MSB]) && (w_sum[c_MSB] != a[c_MSB]);
    assign w_sub_ovf  = (a[c_MSB] != b[c_MSB]) && (w_diff[c_MSB] != a[c_MSB]);
    // True signed a<b: sign of the difference corrected by overflow
    assign w_lt       = w_diff[c_MSB] ^ w_sub_ovf;
    assign w_eq       = (a == b);
    assign w_shamt    = b[SW-1:0];
    assign w_is_shift = (op == c_OP_SLL) || (op == c_OP_SRL) || (op == c_OP_SRA);

    // Single-cycle result from the live operands at the moment of acceptance
    always_comb begin
        w_alu_res = a;
        w_alu_ovf = 1'b0;
        case (op)
            c_OP_OR:    w_alu_res = a | b;
            c_OP_AND:   w_alu_res = a & b;
            c_OP_XOR:   w_alu_res = a ^ b;
            c_OP_NOR:   w_alu_res = ~(a | b);
            c_OP_NOTA:  w_alu_res = ~a;
            c_OP_PASSA: w_alu_res = a;
            c_OP_PASSB: w_alu_res = b;
            c_OP_LUI:   w_alu_res = {a[c_HALF-1:0], {c_HALF{1'b0}}};
            c_OP_ADD: begin
                w_alu_res = w_sum;
                w_alu_ovf = w_add_ovf;
            end
            c_OP_SUB: begin
                w_alu_res = w_diff;
                w_alu_ovf = w_sub_ovf;
            end
            c_OP_SLT:   w_alu_res = {{(WIDTH-1){1'b0}}, w_lt};
            c_OP_SGT:   w_alu_res = {{(WIDTH-1){1'b0}}, (~w_lt & ~w_eq)};
            // Shifts by zero complete immediately with the operand unchanged
            default:    w_alu_res = a;
        endcase
    end

    // One-position shift step of the iterative shifter
    always_comb begin
        w_shift_next = r_acc;
        case (r_op)
            c_OP_SLL: w_shift_next = {r_acc[WIDTH-2:0], 1'b0};
            c_OP_SRL: w_shift_next = {1'b0, r_acc[WIDTH-1:1]};
            default:  w_shift_next = {r_acc[c_MSB], r_acc[WIDTH-1:1]};
        endcase
    end

    // Conditional add step of the shift-add multiplier
    assign w_mul_next = r_acc + (r_mplier[0] ? r_mcand : {WIDTH{1'b0}});

    // Control FSM and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_op     <= 4'd0;
            r_cnt    <= '0;
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_result <= '0;
            r_zero   <= 1'b0;
            r_ovf    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_op <= op;
                        if (op == c_OP_MUL) begin
                            r_acc    <= '0;
                            r_mcand  <= a;
                            r_mplier <= b;
                            r_cnt    <= c_MUL_STEPS;
                            r_state  <= S_MUL;
                        end else if (w_is_shift && (w_shamt != '0)) begin
                            r_acc   <= a;
                            r_cnt   <= {1'b0, w_shamt};
                            r_state <= S_SHIFT;
                        end else begin
                            r_result <= w_alu_res;
                            r_zero   <= (w_alu_res == '0);
                            r_ovf    <= w_alu_ovf;
                            r_state  <= S_DONE;
                        end
                    end
                end
                S_SHIFT: begin
                    r_acc <= w_shift_next;
                    r_cnt <= r_cnt - c_CNT_ONE;
                    if (r_cnt == c_CNT_ONE) begin
                        r_result <= w_shift_next;
                        r_zero   <= (w_shift_next == '0);
                        r_ovf    <= 1'b0;
                        r_state  <= S_DONE;
                    end
                end
                S_MUL: begin
                    r_acc    <= w_mul_next;
                    r_mcand  <= {r_mcand[WIDTH-2:0], 1'b0};
                    r_mplier <= {1'b0, r_mplier[WIDTH-1:1]};
                    r_cnt    <= r_cnt - c_CNT_ONE;
                    if (r_cnt == c_CNT_ONE) begin
                        r_result <= w_mul_next;
                        r_zero   <= (w_mul_next == '0);
                        r_ovf    <= 1'b0;
                        r_state  <= S_DONE;
                    end
                end
                default: begin
                    if (out_ready) begin
                        r_state <= S_IDLE;
                    end
                end
            endcase
        end
    end

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_DONE);
    assign result    = r_result;
    assign zero      = r_zero;
    assign ovf       = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_iter_alu.sv
`default_nettype none
// ============================================================================
//  Module      : tb_iter_alu
//  Description : Directed self-checking bench for iter_alu (WIDTH=32).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_iter_alu;

    localparam int c_W       = 32;
    localparam int c_TIMEOUT = 200;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       op;
    logic [c_W-1:0]   a;
    logic [c_W-1:0]   b;
    logic             out_valid;
    logic             out_ready;
    logic [c_W-1:0]   result;
    logic             zero;
    logic             ovf;

    int n_cmp;
    int n_err;

    iter_alu #(.WIDTH(c_W)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero),
        .ovf       (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Present an operation for one accept edge; returns #1 after that edge
    task automatic issue(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
        op       = o;
        a        = x;
        b        = y;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Count cycles from acceptance until out_valid; 1 means the cycle after accept
    task automatic wait_valid(input string tag, input bit disturb, output int lat);
        lat = 1;
        if (disturb) check_eq({tag, "_busy_in_ready"}, 32'(in_ready), 32'd0);
        while (!out_valid && lat < c_TIMEOUT) begin
            if (disturb) begin
                in_valid = 1'b1;
                a        = $urandom;
                op       = 4'($urandom_range(0, 15));
            end
            @(posedge clk);
            #1;
            lat++;
        end
        in_valid = 1'b0;
        if (!out_valid) check_eq({tag, "_timeout"}, 32'(out_valid), 32'd1);
    endtask

    // Accept the result and confirm the block returns to IDLE
    task automatic handoff(input string tag);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check_eq({tag, "_idle_valid"}, 32'(out_valid), 32'd0);
        check_eq({tag, "_idle_ready"}, 32'(in_ready), 32'd1);
    endtask

    task automatic run_op(input string tag, input logic [3:0] o, input logic [31:0] x,
                          input logic [31:0] y, input logic [31:0] exp_res, input bit exp_zero,
                          input bit exp_ovf, input int exp_lat, input bit disturb);
        int lat;
        issue(o, x, y);
        wait_valid(tag, disturb, lat);
        check_eq({tag, "_result"}, result, exp_res);
        check_eq({tag, "_zero"}, 32'(zero), 32'(exp_zero));
        check_eq({tag, "_ovf"}, 32'(ovf), 32'(exp_ovf));
        check_eq({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        handoff(tag);
    endtask

    initial begin
        int lat;
        n_cmp     = 0;
        n_err     = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        op        = 4'd0;
        a         = '0;
        b         = '0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_in_ready", 32'(in_ready), 32'd1);
        check_eq("rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("rst_result", result, 32'd0);
        check_eq("rst_zero", 32'(zero), 32'd0);
        check_eq("rst_ovf", 32'(ovf), 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single-cycle operations
        run_op("add_ovf", 4'd8,  32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0, 1'b1, 1, 1'b0);
        run_op("sub_zero",4'd9,  32'h0000_0005, 32'h0000_0005, 32'h0000_0000, 1'b1, 1'b0, 1, 1'b0);
        run_op("sub_ovf", 4'd9,  32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b0, 1'b1, 1, 1'b0);
        run_op("slt",     4'd10, 32'h8000_0000, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1, 1'b0);
        run_op("sgt",     4'd11, 32'h8000_0000, 32'h7FFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 1, 1'b0);
        run_op("lui",     4'd7,  32'h1234_ABCD, 32'h0000_0000, 32'hABCD_0000, 1'b0, 1'b0, 1, 1'b0);
        run_op("nor",     4'd3,  32'h0000_0000, 32'h0000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, 1, 1'b0);
        run_op("xor",     4'd2,  32'hA5A5_A5A5, 32'hFFFF_0000, 32'h5A5A_A5A5, 1'b0, 1'b0, 1, 1'b0);

        // Iterative shifts
        run_op("sra4",    4'd14, 32'hF000_0000, 32'h0000_0004, 32'hFF00_0000, 1'b0, 1'b0, 5, 1'b0);
        run_op("srl4",    4'd13, 32'hF000_0000, 32'h0000_0004, 32'h0F00_0000, 1'b0, 1'b0, 5, 1'b0);
        run_op("sll0",    4'd12, 32'h0000_0001, 32'h0000_0020, 32'h0000_0001, 1'b0, 1'b0, 1, 1'b0);
        run_op("sll31",   4'd12, 32'h0000_0001, 32'h0000_001F, 32'h8000_0000, 1'b0, 1'b0, 32, 1'b0);

        // Shift-add multiply, with input noise during the first one
        run_op("mul_a",   4'd15, 32'h0001_0003, 32'h0000_0005, 32'h0005_000F, 1'b0, 1'b0, 33, 1'b1);
        run_op("mul_b",   4'd15, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 33, 1'b0);

        // Backpressure: result held for 10 cycles, then back-to-back accept
        issue(4'd8, 32'd2, 32'd3);
        wait_valid("bp", 1'b0, lat);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            check_eq("bp_hold_result", result, 32'd5);
            check_eq("bp_hold_valid", 32'(out_valid), 32'd1);
            check_eq("bp_hold_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        op        = 4'd5;
        a         = 32'h0000_0055;
        b         = 32'h0000_0000;
        in_valid  = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check_eq("bp_release_valid", 32'(out_valid), 32'd0);
        check_eq("bp_release_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check_eq("b2b_valid", 32'(out_valid), 32'd1);
        check_eq("b2b_result", result, 32'h0000_0055);
        handoff("b2b");

        // Asynchronous reset in the middle of a multiply
        issue(4'd15, 32'h0000_0007, 32'h0000_0009);
        repeat (9) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_eq("arst_out_valid", 32'(out_valid), 32'd0);
        check_eq("arst_result", result, 32'd0);
        check_eq("arst_ovf", 32'(ovf), 32'd0);
        check_eq("arst_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_eq("arst_no_result", 32'(out_valid), 32'd0);
        run_op("passb",   4'd6,  32'h0000_0000, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, 1'b0, 1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
